// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus used by the fetch stage.
// The master side issues req/addr; the slave side returns ack/rdata.
interface if_fetch_stage_if #(
    parameter int unsigned LEN = 32
);
    logic           imem_req;
    logic [LEN-1:0] imem_addr;
    logic           imem_ack;
    logic [LEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register: req/ack imem port, one-entry skid, branch squash.
// Optional macro FETCH_COUNTER_EN adds a saturating fetch_count output.
module if_fetch_stage #(
    parameter int unsigned    LEN      = 32,
    parameter logic [LEN-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [LEN-1:0]    branch_address,
    if_fetch_stage_if.master  imem,
    output logic [LEN-1:0]    instruction,
    output logic [LEN-1:0]    pc,
    output logic              valid
`ifdef FETCH_COUNTER_EN
    ,
    output logic [15:0]       fetch_count
`endif
);

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DISCARD,
        ST_FULL
    } state_t;

    localparam logic [LEN-1:0] STEP      = LEN'(4);
    localparam logic [LEN-1:0] WORD_MASK = ~LEN'(3);

    state_t         state, state_n;
    logic           run;
    logic [LEN-1:0] fpc;
    logic [LEN-1:0] fpc_inc;
    logic [LEN-1:0] hold_addr;
    logic [LEN-1:0] cur_addr;
    logic [LEN-1:0] skid_instr;
    logic [LEN-1:0] skid_pc;
    logic           req;
    logic           xfer;
    logic           adv;
    logic           load_out;
    logic           load_skid;
    logic           drain_skid;

    // run gates the first request to the first edge after reset is released
    assign req      = run && (state != ST_FULL);
    assign xfer     = req && imem.imem_ack;
    assign fpc_inc  = fpc + STEP;
    assign cur_addr = (state == ST_DISCARD) ? hold_addr : fpc;

    assign imem.imem_req  = req;
    assign imem.imem_addr = cur_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        adv        = 1'b0;
        load_out   = 1'b0;
        load_skid  = 1'b0;
        drain_skid = 1'b0;
        if (branch_taken) begin
            state_n = (req && !imem.imem_ack) ? ST_DISCARD : ST_FETCH;
        end else begin
            case (state)
                ST_FETCH, ST_WAIT: begin
                    if (xfer) begin
                        adv = 1'b1;
                        if (!valid || !freeze) begin
                            load_out = 1'b1;
                            state_n  = ST_FETCH;
                        end else begin
                            load_skid = 1'b1;
                            state_n   = ST_FULL;
                        end
                    end else if (req) begin
                        state_n = ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (xfer) begin
                        state_n = ST_FETCH;
                    end
                end
                ST_FULL: begin
                    if (!freeze) begin
                        drain_skid = 1'b1;
                        state_n    = ST_FETCH;
                    end
                end
                default: state_n = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            fpc         <= RESET_PC;
            hold_addr   <= '0;
            instruction <= '0;
            pc          <= '0;
            valid       <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else begin
            run <= 1'b1;
            if (branch_taken) begin
                // the squashed request keeps its address on the bus until it is acked
                hold_addr  <= cur_addr;
                fpc        <= branch_address & WORD_MASK;
                valid      <= 1'b0;
                skid_instr <= '0;
                skid_pc    <= '0;
            end else begin
                if (adv) begin
                    fpc <= fpc_inc;
                end
                if (load_out) begin
                    instruction <= imem.imem_rdata;
                    pc          <= fpc_inc;
                    valid       <= 1'b1;
                end else if (drain_skid) begin
                    instruction <= skid_instr;
                    pc          <= skid_pc;
                    valid       <= 1'b1;
                end else if (!freeze) begin
                    valid <= 1'b0;
                end
                if (load_skid) begin
                    skid_instr <= imem.imem_rdata;
                    skid_pc    <= fpc_inc;
                end
            end
        end
    end

`ifdef FETCH_COUNTER_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
        end else if ((load_out || drain_skid) && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, wait states, freeze/skid, branch squash, PC wrap, async reset.
module tb_if_fetch_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        ack;

    logic [31:0] instruction, pc;
    logic        valid;
    logic [31:0] instruction_w, pc_w;
    logic        valid_w;
`ifdef FETCH_COUNTER_EN
    logic [15:0] fetch_count, fetch_count_w;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    if_fetch_stage_if #(.LEN(32)) bus ();
    if_fetch_stage_if #(.LEN(32)) bus_w ();

    // Memory models: the word returned encodes the low half of its address.
    assign bus.imem_ack     = ack;
    assign bus.imem_rdata   = {bus.imem_addr[15:0], 16'hC0DE};
    assign bus_w.imem_ack   = 1'b1;
    assign bus_w.imem_rdata = 32'h1234_5678;

    if_fetch_stage #(.LEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem           (bus),
        .instruction    (instruction),
        .pc             (pc),
        .valid          (valid)
`ifdef FETCH_COUNTER_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    if_fetch_stage #(.LEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clock          (clock),
        .reset          (reset),
        .freeze         (1'b0),
        .branch_taken   (1'b0),
        .branch_address (32'h0),
        .imem           (bus_w),
        .instruction    (instruction_w),
        .pc             (pc_w),
        .valid          (valid_w)
`ifdef FETCH_COUNTER_EN
        ,
        .fetch_count    (fetch_count_w)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0; ack = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0; ack = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.imem_req, valid, pc, instruction} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_out: got req=%b valid=%b pc=%h instr=%h, want 0 0 0 0",
                     bus.imem_req, valid, pc, instruction);
        end
`ifdef FETCH_COUNTER_EN
        checks++;
        if (fetch_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_count: got %h want 0000", fetch_count);
        end
`endif
        reset = 1'b1;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL release_noreq: got req=%b want 0", bus.imem_req);
        end
        tick();
        checks++;
        if ({bus.imem_req, bus.imem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h valid=%b, want 1 00000000 0",
                     bus.imem_req, bus.imem_addr, valid);
        end
    endtask

    task automatic test_zero_wait();
        apply_reset();
        ack = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({valid, pc, instruction, bus.imem_addr} !==
                {1'b1, 32'(4 * k), mem_word(32'(4 * k - 4)), 32'(4 * k)}) begin
                errors++;
                $display("FAIL zw_stream[%0d]: got valid=%b pc=%h instr=%h addr=%h, want 1 %h %h %h",
                         k, valid, pc, instruction, bus.imem_addr,
                         32'(4 * k), mem_word(32'(4 * k - 4)), 32'(4 * k));
            end
        end
`ifdef FETCH_COUNTER_EN
        checks++;
        if (fetch_count !== 16'd6) begin
            errors++;
            $display("FAIL zw_count: got %0d want 6", fetch_count);
        end
`endif
    endtask

    task automatic test_multicycle();
        apply_reset();
        tick();
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < 3; c++) begin
                ack = (c == 2);
                checks++;
                if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'(4 * n)}) begin
                    errors++;
                    $display("FAIL mc_addr_stable[%0d.%0d]: got req=%b addr=%h, want 1 %h",
                             n, c, bus.imem_req, bus.imem_addr, 32'(4 * n));
                end
                tick();
                checks++;
                if (c < 2) begin
                    if (valid !== 1'b0) begin
                        errors++;
                        $display("FAIL mc_valid_low[%0d.%0d]: got valid=%b want 0", n, c, valid);
                    end
                end else if ({valid, pc, instruction} !== {1'b1, 32'(4 * n + 4), mem_word(32'(4 * n))}) begin
                    errors++;
                    $display("FAIL mc_accept[%0d]: got valid=%b pc=%h instr=%h, want 1 %h %h",
                             n, valid, pc, instruction, 32'(4 * n + 4), mem_word(32'(4 * n)));
                end
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_freeze();
        apply_reset();
        ack = 1'b1;
        tick();
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({valid, pc, instruction, bus.imem_req} !== {1'b1, 32'h4, mem_word(32'h0), 1'b0}) begin
                errors++;
                $display("FAIL frz_hold[%0d]: got valid=%b pc=%h instr=%h req=%b, want 1 00000004 %h 0",
                         i, valid, pc, instruction, bus.imem_req, mem_word(32'h0));
            end
        end
        freeze = 1'b0;
        tick();
        checks++;
        if ({valid, pc, instruction, bus.imem_req, bus.imem_addr} !==
            {1'b1, 32'h8, mem_word(32'h4), 1'b1, 32'h8}) begin
            errors++;
            $display("FAIL frz_release: got valid=%b pc=%h instr=%h req=%b addr=%h, want 1 00000008 %h 1 00000008",
                     valid, pc, instruction, bus.imem_req, bus.imem_addr, mem_word(32'h4));
        end
        tick();
        checks++;
        if ({valid, pc, instruction} !== {1'b1, 32'hC, mem_word(32'h8)}) begin
            errors++;
            $display("FAIL frz_next: got valid=%b pc=%h instr=%h, want 1 0000000c %h",
                     valid, pc, instruction, mem_word(32'h8));
        end
`ifdef FETCH_COUNTER_EN
        checks++;
        if (fetch_count !== 16'd3) begin
            errors++;
            $display("FAIL frz_count: got %0d want 3", fetch_count);
        end
`endif
    endtask

    task automatic test_branch();
        apply_reset();
        ack = 1'b1;
        tick();
        repeat (4) tick();
        checks++;
        if ({valid, pc, bus.imem_addr} !== {1'b1, 32'h10, 32'h10}) begin
            errors++;
            $display("FAIL br_setup: got valid=%b pc=%h addr=%h, want 1 00000010 00000010",
                     valid, pc, bus.imem_addr);
        end
        ack = 1'b0;
        freeze = 1'b1;
        tick();
        branch_taken = 1'b1;
        branch_address = 32'h43;
        tick();
        checks++;
        if ({valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL br_flush: got valid=%b req=%b addr=%h, want 0 1 00000010",
                     valid, bus.imem_req, bus.imem_addr);
        end
        branch_taken = 1'b0;
        freeze = 1'b0;
        tick();
        checks++;
        if ({valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h10}) begin
            errors++;
            $display("FAIL br_discard_hold: got valid=%b req=%b addr=%h, want 0 1 00000010",
                     valid, bus.imem_req, bus.imem_addr);
        end
        ack = 1'b1;
        tick();
        checks++;
        if ({valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h40}) begin
            errors++;
            $display("FAIL br_drop: got valid=%b req=%b addr=%h, want 0 1 00000040",
                     valid, bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if ({valid, pc, instruction} !== {1'b1, 32'h44, mem_word(32'h40)}) begin
            errors++;
            $display("FAIL br_target: got valid=%b pc=%h instr=%h, want 1 00000044 %h",
                     valid, pc, instruction, mem_word(32'h40));
        end
`ifdef FETCH_COUNTER_EN
        checks++;
        if (fetch_count !== 16'd5) begin
            errors++;
            $display("FAIL br_count: got %0d want 5", fetch_count);
        end
`endif
    endtask

    task automatic test_branch_ack();
        apply_reset();
        ack = 1'b1;
        tick();
        tick();
        branch_taken = 1'b1;
        branch_address = 32'h100;
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
            errors++;
            $display("FAIL bra_drop: got valid=%b req=%b addr=%h, want 0 1 00000100",
                     valid, bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if ({valid, pc, instruction} !== {1'b1, 32'h104, mem_word(32'h100)}) begin
            errors++;
            $display("FAIL bra_target: got valid=%b pc=%h instr=%h, want 1 00000104 %h",
                     valid, pc, instruction, mem_word(32'h100));
        end
    endtask

    task automatic test_branch_discard();
        apply_reset();
        tick();
        branch_taken = 1'b1;
        branch_address = 32'h20;
        tick();
        branch_address = 32'h31;
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h0}) begin
            errors++;
            $display("FAIL brd_hold: got valid=%b req=%b addr=%h, want 0 1 00000000",
                     valid, bus.imem_req, bus.imem_addr);
        end
        ack = 1'b1;
        tick();
        checks++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h30}) begin
            errors++;
            $display("FAIL brd_redirect: got req=%b addr=%h, want 1 00000030",
                     bus.imem_req, bus.imem_addr);
        end
        tick();
        checks++;
        if ({valid, pc} !== {1'b1, 32'h34}) begin
            errors++;
            $display("FAIL brd_target: got valid=%b pc=%h, want 1 00000034", valid, pc);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        tick();
        checks++;
        if ({bus_w.imem_req, bus_w.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL wrap_first_req: got req=%b addr=%h, want 1 fffffffc",
                     bus_w.imem_req, bus_w.imem_addr);
        end
        tick();
        checks++;
        if ({valid_w, pc_w, instruction_w, bus_w.imem_addr} !== {1'b1, 32'h0, 32'h1234_5678, 32'h0}) begin
            errors++;
            $display("FAIL wrap_pc: got valid=%b pc=%h instr=%h addr=%h, want 1 00000000 12345678 00000000",
                     valid_w, pc_w, instruction_w, bus_w.imem_addr);
        end
        tick();
        checks++;
        if ({valid_w, pc_w} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL wrap_next: got valid=%b pc=%h, want 1 00000004", valid_w, pc_w);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        freeze = 1'b1;
        tick();
        checks++;
        if ({valid, pc, bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4, 1'b1, 32'h4}) begin
            errors++;
            $display("FAIL rm_pre: got valid=%b pc=%h req=%b addr=%h, want 1 00000004 1 00000004",
                     valid, pc, bus.imem_req, bus.imem_addr);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.imem_req, valid, pc} !== {1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL rm_async: got req=%b valid=%b pc=%h, want 0 0 00000000",
                     bus.imem_req, valid, pc);
        end
`ifdef FETCH_COUNTER_EN
        checks++;
        if (fetch_count !== 16'h0) begin
            errors++;
            $display("FAIL rm_count: got %h want 0000", fetch_count);
        end
`endif
        tick();
        reset = 1'b1;
        freeze = 1'b0;
        tick();
        checks++;
        if ({bus.imem_req, bus.imem_addr, valid} !== {1'b1, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL rm_restart: got req=%b addr=%h valid=%b, want 1 00000000 0",
                     bus.imem_req, bus.imem_addr, valid);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_multicycle();
        test_freeze();
        test_branch();
        test_branch_ack();
        test_branch_discard();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
